// File: rtl/btb_assoc_predictor.sv
// Set-associative branch target buffer with per-entry saturating counters, tree pseudo-LRU
// replacement, bulk flush and saturating performance counters. Lookup is purely combinational.
module btb_assoc_predictor #(
  parameter int XLEN     = 32,
  parameter int SETS     = 16,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_fetch,
  output logic [XLEN-1:0]     predicted_target,
  output logic                branch_prediction,
  output logic                btb_hit,
  output logic [CTR_BITS-1:0] hit_ctr,
  input  logic                update_en,
  input  logic [XLEN-1:0]     update_pc,
  input  logic                update_taken,
  input  logic [XLEN-1:0]     update_target,
  input  logic                update_mispred,
  input  logic                flush_en,
  output logic [STAT_W-1:0]   stat_updates,
  output logic [STAT_W-1:0]   stat_mispreds
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = XLEN - 2 - IDX_W;
  localparam int LVL    = (WAYS > 1) ? $clog2(WAYS) : 0;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic                valid_q  [SETS][WAYS];
  logic                valid_d  [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
  logic [TAG_W-1:0]    tag_d    [SETS][WAYS];
  logic [XLEN-1:0]     target_q [SETS][WAYS];
  logic [XLEN-1:0]     target_d [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_d    [SETS][WAYS];
  logic [PLRU_W-1:0]   plru_q   [SETS];
  logic [PLRU_W-1:0]   plru_d   [SETS];
  logic [STAT_W-1:0]   stat_updates_q, stat_updates_d;
  logic [STAT_W-1:0]   stat_mispreds_q, stat_mispreds_d;

  logic [IDX_W-1:0] fidx, uidx;
  logic [TAG_W-1:0] ftag, utag;
  logic             u_hit, inv_found, upd_ok;
  logic [WAY_W-1:0] u_way, inv_way, alloc_way;
  logic             unused_pc_bits;

  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                   input logic taken);
    if (taken) return (c == CTR_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

  // Tree nodes are stored heap-ordered (node n at bit n-1); a node bit points at its LRU child.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
    int n;
    logic [WAY_W-1:0]  v;
    logic [PLRU_W-1:0] sh;
    n = 1;
    v = '0;
    for (int l = 0; l < LVL; l++) begin
      sh = t >> (n - 1);
      v  = (v << 1) | WAY_W'(sh[0]);
      n  = 2 * n + int'(sh[0]);
    end
    return v;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                   input logic [WAY_W-1:0] way);
    int n;
    logic [WAY_W-1:0]  sw;
    logic              b;
    logic [PLRU_W-1:0] r;
    n = 1;
    r = t;
    for (int l = 0; l < LVL; l++) begin
      sw = way >> (LVL - 1 - l);
      b  = sw[0];
      r  = (r & ~(PLRU_W'(1) << (n - 1))) | (PLRU_W'(!b) << (n - 1));
      n  = 2 * n + int'(b);
    end
    return r;
  endfunction

  assign fidx   = pc_fetch[IDX_W+1:2];
  assign ftag   = pc_fetch[XLEN-1:IDX_W+2];
  assign uidx   = update_pc[IDX_W+1:2];
  assign utag   = update_pc[XLEN-1:IDX_W+2];
  assign upd_ok = update_en && !flush_en;
  assign unused_pc_bits = ^update_pc[1:0];

  always_comb begin
    btb_hit          = 1'b0;
    hit_ctr          = '0;
    predicted_target = pc_fetch + XLEN'(4);
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[fidx][w] && tag_q[fidx][w] == ftag) begin
        btb_hit          = 1'b1;
        hit_ctr          = ctr_q[fidx][w];
        predicted_target = target_q[fidx][w];
      end
    end
    branch_prediction = btb_hit && hit_ctr[CTR_BITS-1];
  end

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[uidx][w] && tag_q[uidx][w] == utag) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!valid_q[uidx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    alloc_way = inv_found ? inv_way : plru_victim(plru_q[uidx]);
  end

  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    target_d        = target_q;
    ctr_d           = ctr_q;
    plru_d          = plru_q;
    stat_updates_d  = stat_updates_q;
    stat_mispreds_d = stat_mispreds_q;
    if (flush_en) begin
      valid_d = '{default: '0};
      plru_d  = '{default: '0};
    end else if (upd_ok) begin
      stat_updates_d = sat_inc(stat_updates_q);
      if (update_mispred) stat_mispreds_d = sat_inc(stat_mispreds_q);
      if (u_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == u_way) begin
            ctr_d[uidx][w] = ctr_next(ctr_q[uidx][w], update_taken);
            if (update_taken) target_d[uidx][w] = update_target;
          end
        end
        plru_d[uidx] = plru_touch(plru_q[uidx], u_way);
      end else if (update_taken) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == alloc_way) begin
            valid_d[uidx][w]  = 1'b1;
            tag_d[uidx][w]    = utag;
            target_d[uidx][w] = update_target;
            ctr_d[uidx][w]    = CTR_WEAK;
          end
        end
        plru_d[uidx] = plru_touch(plru_q[uidx], alloc_way);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '{default: '0};
      ctr_q           <= '{default: '0};
      plru_q          <= '{default: '0};
      stat_updates_q  <= '0;
      stat_mispreds_q <= '0;
    end else begin
      valid_q         <= valid_d;
      ctr_q           <= ctr_d;
      plru_q          <= plru_d;
      stat_updates_q  <= stat_updates_d;
      stat_mispreds_q <= stat_mispreds_d;
    end
  end

  // Tag and target payload only matter behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign stat_updates  = stat_updates_q;
  assign stat_mispreds = stat_mispreds_q;

endmodule
